rr_mux_stream: RTL and testbench
================================

// Module: rr_mux_stream
// PURPOSE
//  Parametrised N-channel, W-bit stream multiplexer with round-robin select and a registered output stage.
//  Generalises the 2:1 combinational mux to N valid/ready inputs feeding one output; select is generated
//  internally by a fair arbiter instead of a sel pin. Sits between several producers and one shared consumer.
// PARAMETERS
//  N_CH   4   number of input channels; legal range 2..16
//  W      8   data width per channel, bits; >=1
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   N_CH       per-channel valid
//  in_data    in   N_CH*W     packed data, channel i at [i*W +: W]
//  in_ready   out  N_CH       per-channel ready (one-hot or zero)
//  out_valid  out  1          output register holds a word
//  out_data   out  W          registered data
//  out_ch     out  $clog2(N_CH) index of channel that supplied out_data
//  out_ready  in   1          consumer accepts word
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_ch=0, rr pointer=N_CH-1 (ch0 highest priority after reset).
//  - Output stage is 2-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
//  - load = (EMPTY | out_ready) & |in_valid. On load: out_data<=in_data[grant], out_ch<=grant, FULL.
//  - FULL & out_ready & no load -> EMPTY. FULL & ~out_ready -> hold out_data/out_ch/out_valid stable.
//  - Latency 1 cycle input->output; throughput 1 word/cycle when out_ready held high.
//  - grant: first channel with in_valid, searching ptr+1, ptr+2, ... mod N_CH (wrap-around).
//  - in_ready[i] = (i==grant) & |in_valid & (EMPTY | out_ready); combinational on out_ready, by design.
//  - ptr<=grant only on a transfer (load); no transfer -> ptr unchanged.
//  - Simultaneous out_ready drain and new load in same cycle: load wins, stays FULL, no bubble.
//  - No in_valid: in_ready=0, no load, ptr unchanged.
//  - Producer deasserting in_valid before handshake is legal; arbiter re-evaluates each cycle.
//  - rst mid-transfer: output word discarded, state/ptr return to reset values next edge; in_ready=0 during rst.
// CONFIGURATION
//  - Macro RR_MUX_STREAM_INVERT_EN:
//    defined -> extra port `invert  in  N_CH`: per-channel polarity; out_data <= in_data[grant] ^ {W{invert[grant]}}
//               (inverter realised as mux of d and ~d, sampled at load time).
//    undefined -> no invert port; data passed unmodified. All other behaviour identical.
// STRUCTURE
//  - Package rr_mux_stream_pkg: typedef enum logic {EMPTY, FULL} out_state_t; localparams DEF_N_CH=4, DEF_W=8.
//  - Sub-module rr_arbiter #(N_CH): inputs clk, rst, req[N_CH], advance; outputs grant_idx, grant_vld.
//    Owns rr pointer. Data select is an indexed mux in the top.
// TESTING
//  1. Reset: rst=1 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout.
//  2. All 4 ch valid, data ch_i=8'h10+i, out_ready=1 -> outputs 10,11,12,13,10,... out_ch 0,1,2,3,0, one per cycle.
//  3. Backpressure: out_ready=0 after first word 8'hA5 -> out_data holds A5 for 5 cycles, in_ready=0; release -> next word next cycle.
//  4. Wrap/fairness: only ch3 and ch0 valid, ptr at 3 -> grant order 0,3,0,3; ch1 raised later granted before ch3 if after ch0.
//  5. Reset mid-stream: rst asserted while FULL with ch2 word -> next cycle out_valid=0, then first grant goes to ch0.
//  6. With RR_MUX_STREAM_INVERT_EN: invert=4'b0010, ch1 data 8'h0F -> out_data=8'hF0, out_ch=1; ch0 data 8'h0F -> 8'h0F.

Source files
------------

// File: rtl/rr_mux_stream_pkg.sv
// ============================================================================
// Module : rr_mux_stream_pkg
// Brief  : Shared types and defaults for the round-robin stream multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_mux_stream_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam int DEF_N_CH = 4;
   localparam int DEF_W    = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; owns the priority pointer (last granted index).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import rr_mux_stream_pkg::*;
#(
   parameter int N_CH = DEF_N_CH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         req,
   input  logic                    advance,
   output logic [$clog2(N_CH)-1:0] grant_idx,
   output logic                    grant_vld
);

   localparam int IW = $clog2(N_CH);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;

   // Walk candidates from farthest (ptr+N_CH) down to nearest (ptr+1) so the
   // nearest requester after the pointer is the last, and winning, assignment.
   always_comb begin
      w_idx     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int k = N_CH; k >= 1; k--) begin
         w_idx = IW'((int'(r_ptr) + k) % N_CH);
         if (req[w_idx]) begin
            grant_idx = w_idx;
            grant_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= IW'(N_CH - 1);
      end else if (advance) begin
         r_ptr <= grant_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_mux_stream.sv
// ============================================================================
// Module : rr_mux_stream
// Brief  : N-channel valid/ready stream mux, round-robin select, registered
//          output. Optional per-channel inversion via RR_MUX_STREAM_INVERT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_mux_stream
   import rr_mux_stream_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int W    = DEF_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*W-1:0]       in_data,
   output logic [N_CH-1:0]         in_ready,
   output logic                    out_valid,
   output logic [W-1:0]            out_data,
   output logic [$clog2(N_CH)-1:0] out_ch,
`ifdef RR_MUX_STREAM_INVERT_EN
   input  logic [N_CH-1:0]         invert,
`endif
   input  logic                    out_ready
);

   localparam int IW = $clog2(N_CH);

   out_state_t    r_state;
   out_state_t    w_state_nxt;
   logic [W-1:0]  r_data;
   logic [IW-1:0] r_ch;
   logic [IW-1:0] w_grant;
   logic          w_grant_vld;
   logic          w_load;
   logic [W-1:0]  w_raw;
   logic [W-1:0]  w_sel_data;
   logic [W-1:0]  w_ch_data [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign w_ch_data[i] = in_data[i*W +: W];
   end

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (w_load),
      .grant_idx (w_grant),
      .grant_vld (w_grant_vld)
   );

   // Ready depends combinationally on out_ready so a draining word and a new
   // word can swap in the same cycle without a bubble.
   assign w_load = (r_state == EMPTY || out_ready) && w_grant_vld && !rst;
   assign w_raw  = w_ch_data[w_grant];

`ifdef RR_MUX_STREAM_INVERT_EN
   assign w_sel_data = invert[w_grant] ? ~w_raw : w_raw;
`else
   assign w_sel_data = w_raw;
`endif

   always_comb begin
      in_ready = '0;
      if (w_load) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_load) w_state_nxt = FULL;
         FULL: begin
            if (w_load) begin
               w_state_nxt = FULL;
            end else if (out_ready) begin
               w_state_nxt = EMPTY;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_ch   <= '0;
      end else if (w_load) begin
         r_data <= w_sel_data;
         r_ch   <= w_grant;
      end
   end

   assign out_valid = (r_state == FULL);
   assign out_data  = r_data;
   assign out_ch    = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_stream.sv
// ============================================================================
// Module : tb_rr_mux_stream
// Brief  : Randomised bench for rr_mux_stream with directed literal scenarios.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_stream;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_CH-1:0]   in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [1:0]        out_ch;
   logic              out_ready;
   logic [N_CH-1:0]   invert;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: contents of the output register and last granted channel.
   bit           m_full = 1'b0;
   logic [W-1:0] m_data = '0;
   int           m_ch   = 0;
   int           m_ptr  = N_CH - 1;

   always #5 clk = ~clk;

   rr_mux_stream #(
      .N_CH (N_CH),
      .W    (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
`ifdef RR_MUX_STREAM_INVERT_EN
      .invert    (invert),
`endif
      .out_ready (out_ready)
   );

   function automatic int model_grant(input logic [N_CH-1:0] v, input int ptr);
      for (int k = 1; k <= N_CH; k++) begin
         if (v[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
      end
      return -1;
   endfunction

   function automatic logic [N_CH-1:0] eff_invert();
`ifdef RR_MUX_STREAM_INVERT_EN
      return invert;
`else
      return '0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model_update
      int g;
      logic [N_CH-1:0] inv;
      if (rst) begin
         m_full = 1'b0;
         m_data = '0;
         m_ch   = 0;
         m_ptr  = N_CH - 1;
      end else begin
         g   = model_grant(in_valid, m_ptr);
         inv = eff_invert();
         if (g >= 0 && (!m_full || out_ready)) begin
            m_data = in_data[g*W +: W] ^ {W{inv[g]}};
            m_ch   = g;
            m_full = 1'b1;
            m_ptr  = g;
         end else if (out_ready) begin
            m_full = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : compare
      int g;
      logic [N_CH-1:0] exp_rdy;
      exp_rdy = '0;
      g = model_grant(in_valid, m_ptr);
      if (!rst && g >= 0 && (!m_full || out_ready)) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
         check("out_data", 32'(out_data), 32'(m_data));
         check("out_ch", 32'(out_ch), 32'(m_ch));
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 4'hF;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready = 1'b1;
      invert    = '0;

      // Reset held with every channel requesting.
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd0);
      end
      #1 rst = 1'b0;

      // Full-rate rotation through all channels.
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("rot_data", 32'(out_data), 32'(8'h10 + (j % 4)));
         check("rot_ch", 32'(out_ch), 32'(j % 4));
      end

      // Backpressure holds the word and blocks all producers.
      #1 in_valid = 4'h0;
      @(negedge clk);
      check("drain_valid", 32'(out_valid), 32'd0);
      #1 begin
         in_valid  = 4'h1;
         in_data   = {8'h33, 8'h22, 8'h5A, 8'hA5};
         out_ready = 1'b0;
      end
      @(negedge clk);
      check("bp_first", 32'(out_data), 32'hA5);
      #1 in_valid = 4'hF;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_data", 32'(out_data), 32'hA5);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ch", 32'(out_ch), 32'd1);
      check("bp_release_data", 32'(out_data), 32'h5A);

      // Wrap-around fairness between ch3 and ch0, then ch1 joins.
      #1 begin
         rst      = 1'b1;
         in_valid = 4'b1001;
         in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      end
      @(negedge clk);
      #1 rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("wrap_ch", 32'(out_ch), (j % 2 == 0) ? 32'd0 : 32'd3);
      end
      #1 in_valid = 4'b1011;
      @(negedge clk);
      check("join_ch1", 32'(out_ch), 32'd1);
      @(negedge clk);
      check("join_ch3", 32'(out_ch), 32'd3);
      @(negedge clk);
      check("join_ch0", 32'(out_ch), 32'd0);

      // Reset while holding a ch2 word.
      #1 in_valid = 4'b0100;
      @(negedge clk);
      check("mid_ch2", 32'(out_ch), 32'd2);
      #1 begin
         rst      = 1'b1;
         in_valid = 4'hF;
      end
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_after_ch", 32'(out_ch), 32'd0);
      check("mid_after_data", 32'(out_data), 32'h10);

`ifdef RR_MUX_STREAM_INVERT_EN
      #1 begin
         in_valid = 4'b0010;
         in_data  = {8'h13, 8'h12, 8'h0F, 8'h0F};
         invert   = 4'b0010;
      end
      @(negedge clk);
      check("inv_ch1_data", 32'(out_data), 32'hF0);
      check("inv_ch1_ch", 32'(out_ch), 32'd1);
      #1 in_valid = 4'b0001;
      @(negedge clk);
      check("inv_ch0_data", 32'(out_data), 32'h0F);
`endif

      // Random traffic with occasional resets, checked by the compare process.
      for (int c = 0; c < 3000; c++) begin
         #1 begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = N_CH'($urandom);
            in_data   = {$urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            invert    = N_CH'($urandom);
         end
         @(negedge clk);
      end

      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
